// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the hazard sequencer
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        HALT
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       memread_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       uses_rs2_i,
    output logic       lu_o
);

    assign lu_o = memread_i && (rd_i != REG_ZERO) &&
                  ((rd_i == rs1_i) || (uses_rs2_i && (rd_i == rs2_i)));

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush control for load-use, redirects and data-memory waits (perf counters under HAZARD_PERF_EN)
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = 15
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic        usesrs2D,
    input  logic [4:0]  rdE,
    input  logic        memreadE,
    input  logic        branch_takenE,
    input  logic        jumpD,
    input  logic        dmem_busy,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int W = $clog2(WAIT_MAX + 1);
    localparam logic [W-1:0] WAIT_LAST = W'(WAIT_MAX);

    hz_state_t      state_q, state_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   wait_q, wait_d;
    logic           lu, redir;

    load_use_detect u_lu (
        .memread_i  (memreadE),
        .rd_i       (rdE),
        .rs1_i      (rs1D),
        .rs2_i      (rs2D),
        .uses_rs2_i (usesrs2D),
        .lu_o       (lu)
    );

    assign redir       = branch_takenE | pend_q;
    assign wait_d      = !dmem_busy ? '0 : (wait_q == '1) ? wait_q : wait_q + 1'b1;
    assign mem_timeout = (state_q == HALT);

    // State, pending redirect and busy-cycle counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
        end
    end

    // Mealy next-state and stall/flush decode in strict priority order
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        stallM  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        if (!rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (state_q == HALT || dmem_busy) begin
            {stallF, stallD, stallE, stallM} = 4'hf;
            if (state_q != HALT) begin
                state_d = (wait_q == WAIT_LAST) ? HALT : MEM_WAIT;
                pend_d  = branch_takenE | (state_q == MEM_WAIT && pend_q);
            end
        end else begin
            state_d = RUN;
            if (redir) begin
                flushD = 1'b1;
                flushE = 1'b1;
                pend_d = 1'b0;
            end else if (lu) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else begin
                flushD = jumpD;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Count stalled and bubbled cycles, frozen once halted
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != HALT) begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stallF};
            flush_cnt_q <= flush_cnt_q + {31'd0, flushE};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed checks of hazard_sequencer with WAIT_MAX = 4
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1D, rs2D, rdE;
    logic        usesrs2D, memreadE, branch_takenE, jumpD, dmem_busy;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;
    int          errors = 0;
    int          checks = 0;

    hazard_sequencer #(.WAIT_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1D          (rs1D),
        .rs2D          (rs2D),
        .usesrs2D      (usesrs2D),
        .rdE           (rdE),
        .memreadE      (memreadE),
        .branch_takenE (branch_takenE),
        .jumpD         (jumpD),
        .dmem_busy     (dmem_busy),
        .stallF        (stallF),
        .stallD        (stallD),
        .stallE        (stallE),
        .stallM        (stallM),
        .flushD        (flushD),
        .flushE        (flushE),
        .mem_timeout   (mem_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0; usesrs2D = 1'b0; memreadE = 1'b0;
        branch_takenE = 1'b0; jumpD = 1'b0; dmem_busy = 1'b0;
    endtask

    // outputs packed as {stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout}
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #2;
        obs = {stallF, stallD, stallE, stallM, flushD, flushE, mem_timeout};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_stall, exp_flush;
`ifdef HAZARD_PERF_EN
        exp_stall = 32'd2;
        exp_flush = 32'd3;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        idle();
        rst = 1'b0;
        cyc(); cyc();
        chk("reset_outputs", 7'b0000_110);
        chk32("reset_stall_cnt", stall_cnt, 32'd0);
        chk32("reset_flush_cnt", flush_cnt, 32'd0);

        cyc(); rst = 1'b1;
        chk("idle", 7'b0000_000);

        cyc(); memreadE = 1'b1; rdE = 5'd8; rs1D = 5'd8;
        chk("load_use_rs1", 7'b1100_010);
        cyc(); memreadE = 1'b0; rdE = 5'd0;
        chk("bubble_in_ex", 7'b0000_000);
        cyc(); memreadE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
        chk("rd_zero_no_stall", 7'b0000_000);
        cyc(); rdE = 5'd9; rs1D = 5'd1; rs2D = 5'd9; usesrs2D = 1'b0;
        chk("rs2_unused_no_stall", 7'b0000_000);
        cyc(); usesrs2D = 1'b1;
        chk("load_use_rs2", 7'b1100_010);
        cyc(); idle(); memreadE = 1'b1; rdE = 5'd8; rs1D = 5'd8; branch_takenE = 1'b1;
        chk("branch_beats_load_use", 7'b0000_110);
        cyc(); idle(); jumpD = 1'b1;
        chk("jump_flush", 7'b0000_100);
        chk32("perf_stall_cnt", stall_cnt, exp_stall);
        chk32("perf_flush_cnt", flush_cnt, exp_flush);
        cyc(); memreadE = 1'b1; rdE = 5'd8; rs1D = 5'd8;
        chk("jump_held_by_load_use", 7'b1100_010);

        cyc(); idle(); dmem_busy = 1'b1;
        chk("wait3_c1", 7'b1111_000);
        cyc(); branch_takenE = 1'b1;
        chk("wait3_c2_branch", 7'b1111_000);
        cyc(); branch_takenE = 1'b0;
        chk("wait3_c3", 7'b1111_000);
        cyc(); dmem_busy = 1'b0;
        chk("wait3_exit_redirect", 7'b0000_110);
        cyc();
        chk("pend_cleared", 7'b0000_000);

        cyc(); dmem_busy = 1'b1;
        cyc(); cyc(); cyc();
        chk("wait4_last_busy", 7'b1111_000);
        cyc(); dmem_busy = 1'b0;
        chk("wait4_no_timeout", 7'b0000_000);

        cyc(); dmem_busy = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("wait5_c5", 7'b1111_000);
        cyc(); dmem_busy = 1'b0;
        chk("halt_entered", 7'b1111_001);
        cyc(); branch_takenE = 1'b1; jumpD = 1'b1;
        chk("halt_sticky", 7'b1111_001);
        cyc(); idle(); rst = 1'b0;
        chk("reset_in_halt", 7'b0000_111);
        cyc();
        chk("reset_left_halt", 7'b0000_110);
        chk32("reset_clears_stall_cnt", stall_cnt, 32'd0);
        cyc(); rst = 1'b1;
        chk("run_after_reset", 7'b0000_000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller for the 5-stage MIPS core. Each cycle it decides which pipeline registers stall and which are flushed. Its `flushE` output drives the flush input of the ID/EX bubble mux. It sequences load-use bubbles, branch/jump redirects and multi-cycle data-memory waits, and it latches a sticky timeout when the data memory never answers.

## Interface
Parameters:
- `WAIT_MAX`, 15: maximum consecutive `dmem_busy` cycles tolerated before timeout; legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset is synchronous and active-low.
- `rs1D`, `rs2D` input 5 each: source registers of the instruction in ID.
- `usesrs2D` input 1: ID instruction reads `rs2D`.
- `rdE` input 5: destination register of the instruction in EX.
- `memreadE` input 1: EX instruction is a load.
- `branch_takenE` input 1: branch resolved taken in EX.
- `jumpD` input 1: jump decoded in ID.
- `dmem_busy` input 1: data memory not ready; MEM access must hold.
- `stallF`, `stallD`, `stallE`, `stallM` output 1 each: hold PC, IF/ID, ID/EX and EX/MEM.
- `flushD` output 1: clear IF/ID.
- `flushE` output 1: select bubble into ID/EX.
- `mem_timeout` output 1: sticky timeout flag.
- `stall_cnt`, `flush_cnt` output 32 each: performance counters (see Configuration).

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Outputs are Mealy: combinational from state, registers and inputs.
- Load-use hazard (`lu`) is asserted when all of the following hold:
  - `memreadE` = 1,
  - `rdE` != 0,
  - `rdE` == `rs1D`, or (`usesrs2D` = 1 and `rdE` == `rs2D`).
- `redir` = `branch_takenE` | `redirect_pend`.
- RUN, and MEM_WAIT when `dmem_busy` = 0, evaluate in strict priority order:
  1. `dmem_busy` = 1: assert all four stalls; all flushes 0. Next state MEM_WAIT. `redirect_pend` <= `branch_takenE`.
  2. `redir`: assert `flushD` and `flushE`; no stalls. Clear `redirect_pend`.
  3. `lu`: assert `stallF`, `stallD`, `flushE`.
  4. `jumpD`: assert `flushD`.
  5. Otherwise, all outputs 0.
- MEM_WAIT with `dmem_busy` = 1: all four stalls high; flushes suppressed. `redirect_pend` |= `branch_takenE`.
- When `dmem_busy` falls in MEM_WAIT, that cycle is evaluated by the RUN rules above and the next state is RUN.
- HALT: all four stalls high, flushes 0, `mem_timeout` = 1. Only reset leaves HALT.
- Jumps are only flushed when no load-use hazard exists. A stalled jump re-evaluates next cycle.

## Timing
- Reset (`rst` = 0 at an edge) sets:
  - state RUN, `redirect_pend` 0, `wait_cnt` 0, `mem_timeout` 0, counters 0.
- While `rst` is low, outputs are forced to `flushD` = `flushE` = 1 and all stalls 0.
- Stall and flush outputs have zero latency: they respond in the same cycle as their inputs.
- `wait_cnt` (width `$clog2(WAIT_MAX+1)`, saturating):
  - cleared on every cycle with `dmem_busy` = 0;
  - incremented on every cycle with `dmem_busy` = 1.
- Timeout: the cycle in which `dmem_busy` = 1 and `wait_cnt` == `WAIT_MAX` − 1 is the last tolerated busy cycle. If `dmem_busy` is still 1 on the next cycle, that is busy cycle `WAIT_MAX`+1: the next state is HALT and `mem_timeout` rises on the following edge.
- If `dmem_busy` drops on the same cycle the timeout would have fired, there is no HALT.
- `branch_takenE` asserted during a wait is never lost; it is issued as a flush on the exit cycle.
- Reset asserted mid-wait or in HALT returns to RUN on the next edge.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments on each cycle with `stallF` = 1;
  - `flush_cnt` increments on each cycle with `flushE` = 1;
  - both wrap at 2^32 and are held during HALT.
- Not defined: counters are not built; `stall_cnt` and `flush_cnt` are tied to 0. Ports remain present.

## Structure
- Shared package `hazard_pkg`:
  - state enum `hz_state_t` (RUN, MEM_WAIT, HALT);
  - `REG_ZERO` = 5'd0.
- One sub-module, `load_use_detect`: pure combinational computation of `lu` from the ID/EX register fields. The FSM, `wait_cnt`, `redirect_pend` and counters stay in `hazard_sequencer`.

## Test plan
- Load-use: `memreadE` = 1, `rdE` = 8, `rs1D` = 8.
  - Required: one cycle of `stallF` = `stallD` = `flushE` = 1.
  - Next cycle, with the bubble in EX (`rdE` = 0): all outputs 0.
- `rdE` = 0 with `memreadE` = 1 and `rs1D` = 0: no stall. Also, `rs2D` match with `usesrs2D` = 0: no stall.
- Taken branch and load-use in the same cycle: `flushD` = `flushE` = 1 and `stallF` = 0 (redirect wins).
- `dmem_busy` high 3 cycles with `branch_takenE` pulsed in cycle 2:
  - cycles 1–3: all stalls high, no flush;
  - cycle 4: `flushD` = `flushE` = 1;
  - `redirect_pend` cleared afterwards.
- `WAIT_MAX` = 4:
  - `dmem_busy` high 4 cycles then low: no timeout.
  - High 5 cycles: HALT, with `mem_timeout` = 1 and all stalls held until `rst` = 0.
- With `HAZARD_PERF_EN`: 2 load-use stalls plus 1 branch give `stall_cnt` = 2 and `flush_cnt` = 3. Without the macro, both read 0.
